// File: rtl/mem_c_readout_pkg.sv
// Shared constants and FSM encoding for the SRAM C readout stage.
package mem_c_readout_pkg;

   localparam int DATA_W     = 22;
   localparam int ADDR_W     = 12;
   localparam int MEM_WORDS  = 4096;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

endpackage

// File: rtl/mem_c_readout_skid_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop both take effect.
module skid_fifo2 #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   // pointer, storage and occupancy update
   always_comb begin
      do_push  = push && ((count_q != 2'd2) || pop);
      do_pop   = pop && (count_q != 2'd0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      count_d  = count_q;
      if (do_push) mem_d[wr_ptr_q] = din;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mem_c_readout.sv
// Drains SRAM C (4096 x 22b) after a multiply, saturating each word to OUT_W
// bits and streaming {data, addr} over valid/ready through a 2-entry skid FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; sat_flag holds last sweep's result
// ST_READ  | issuing reads 0..4095 whenever a FIFO slot is guaranteed
// ST_DRAIN | all reads issued; waiting for FIFO and read pipe to empty
// ST_FIN   | one-cycle done pulse, then back to idle (start ignored)
module mem_c_readout
   import mem_c_readout_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              NCE_C,
   output logic              nwrt_C,
   output logic [ADDR_W-1:0] address_C,
   input  logic [DATA_W-1:0] Out_C,
   output logic [OUT_W-1:0]  out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sat_flag,
   output logic              busy,
   output logic              done
);

   localparam int FW = OUT_W + ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              inflight_q, inflight_d;
   logic              sat_q, sat_d;

   logic              issue;
   logic              over;
   logic [OUT_W-1:0]  sat_data;
   logic              fifo_push, fifo_pop, fifo_empty;
   logic [1:0]        fifo_count;
   logic [1:0]        slots_used;
   logic [FW-1:0]     fifo_din, fifo_dout;

   // clamp detection; with OUT_W == DATA_W nothing can exceed the range
   if (OUT_W < DATA_W) begin : g_sat
      assign over = |Out_C[DATA_W-1:OUT_W];
   end else begin : g_nosat
      assign over = 1'b0;
   end

   assign sat_data = over ? {OUT_W{1'b1}} : Out_C[OUT_W-1:0];

   // a read may issue when the slot it will land in is certain to be free,
   // counting this cycle's pop so steady-state throughput is one word/cycle
   assign fifo_pop   = !fifo_empty && out_ready;
   assign fifo_push  = inflight_q;
   assign slots_used = (fifo_count - {1'b0, fifo_pop}) + {1'b0, inflight_q};
   assign fifo_din   = {sat_data, rd_addr_q};

   // next-state, read issue and status outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      issue      = 1'b0;
      done       = 1'b0;
      rd_addr_d  = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         end
         ST_READ: begin
            if (slots_used < 2'(FIFO_DEPTH)) begin
               issue = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == ADDR_W'(MEM_WORDS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !inflight_q) state_d = ST_FIN;
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (fifo_push && over) sat_d = 1'b1;
      inflight_d = issue;
   end

   // state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_addr_q  <= rd_addr_d;
         inflight_q <= inflight_d;
         sat_q      <= sat_d;
      end
   end

   skid_fifo2 #(.WIDTH(FW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign NCE_C     = !issue;
   assign nwrt_C    = 1'b1;
   assign address_C = cnt_q;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_dout[FW-1:ADDR_W];
   assign out_addr  = fifo_dout[ADDR_W-1:0];
   assign sat_flag  = sat_q;
   assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_mem_c_readout.sv
// Bench for mem_c_readout: SRAM model, randomized backpressure, reference
// model of the expected word stream computed from the memory image.
module tb_mem_c_readout;

   localparam int DATA_W = 22;
   localparam int ADDR_W = 12;
   localparam int OUT_W  = 16;
   localparam int WORDS  = 4096;
   localparam int BUDGET = 30000;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic              NCE_C, nwrt_C;
   logic [ADDR_W-1:0] address_C;
   logic [DATA_W-1:0] Out_C = '0;
   logic [OUT_W-1:0]  out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid, out_ready;
   logic              sat_flag, busy, done;

   logic [DATA_W-1:0] mem [WORDS];

   int n_checks = 0;
   int n_pass   = 0;

   logic [OUT_W-1:0]  got_data [$];
   logic [ADDR_W-1:0] got_addr [$];
   logic              got_sat  [$];
   int done_cnt, done_cyc, first_valid, unstable, post_busy, aborted;
   int rd_count = 0, rd_base = 0, addr_err = 0, nwrt_err = 0, ovf_cnt = 0;

   always #5 clk = ~clk;

   mem_c_readout #(.OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .NCE_C     (NCE_C),
      .nwrt_C    (nwrt_C),
      .address_C (address_C),
      .Out_C     (Out_C),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag),
      .busy      (busy),
      .done      (done)
   );

   // synchronous SRAM C: data appears the cycle after a read is enabled
   always @(posedge clk) begin
      if (rstn && !NCE_C) begin
         Out_C <= mem[address_C];
         if (int'(address_C) != ((rd_count - rd_base) % WORDS)) addr_err <= addr_err + 1;
         rd_count <= rd_count + 1;
      end
      if (nwrt_C !== 1'b1) nwrt_err <= nwrt_err + 1;
      if (dut.u_fifo.count_q > 2'd2) ovf_cnt <= ovf_cnt + 1;
   end

   function automatic logic [OUT_W-1:0] sat_ref(input logic [DATA_W-1:0] v);
      if (v >= (1 << OUT_W)) return {OUT_W{1'b1}};
      return v[OUT_W-1:0];
   endfunction

   // number of received words that differ from the memory image, in order
   function automatic int stream_errors();
      int bad = 0;
      for (int i = 0; i < got_data.size(); i++)
         if (int'(got_addr[i]) != i || got_data[i] !== sat_ref(mem[i])) bad++;
      return bad;
   endfunction

   // runs one sweep from a start pulse, recording the accepted stream
   task automatic run_sweep(input int ready_pct, input int restart_word,
                            input int abort_word, input bit fin_start);
      int cyc = 0, widx = 0, post = -1;
      bit stalled = 0, restarted = 0;
      logic [OUT_W-1:0]  hold_d = '0;
      logic [ADDR_W-1:0] hold_a = '0;
      got_data.delete(); got_addr.delete(); got_sat.delete();
      done_cnt = 0; done_cyc = -1; first_valid = -1; unstable = 0;
      post_busy = 0; aborted = 0;
      @(posedge clk); #1;
      rd_base = rd_count;
      start = 1'b1;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      while (cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (restart_word >= 0 && widx == restart_word && !restarted) begin
            start = 1'b1; restarted = 1;
         end
         if (fin_start && done) start = 1'b1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         #1;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (post >= 0 && busy) post_busy++;
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (stalled && (out_data !== hold_d || out_addr !== hold_a)) unstable++;
            if (out_ready) begin
               got_data.push_back(out_data);
               got_addr.push_back(out_addr);
               got_sat.push_back(sat_flag);
               stalled = 0;
               widx++;
            end else begin
               stalled = 1; hold_d = out_data; hold_a = out_addr;
            end
         end
         if (abort_word >= 0 && widx >= abort_word) begin
            aborted = 1;
            break;
         end
         if (done_cyc >= 0 && post < 0) post = 0;
         else if (post >= 0) post++;
         if (post >= 4) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_v;
      exp_v = {1'b1, 1'b1, 12'd0, 1'b0, 16'd0};
      n_checks++;
      if ({NCE_C, nwrt_C, address_C, out_valid, out_data} !== exp_v)
         $display("FAIL reset_outputs: got %h expected %h",
                  {NCE_C, nwrt_C, address_C, out_valid, out_data}, exp_v);
      else n_pass++;
      n_checks++;
      if ({out_addr, sat_flag, busy, done} !== 15'd0)
         $display("FAIL reset_status: got %h expected 0", {out_addr, sat_flag, busy, done});
      else n_pass++;
   endtask

   task automatic test_continuous();
      int a0, e0, n0;
      for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'(i);
      a0 = addr_err; e0 = nwrt_err;
      run_sweep(100, -1, -1, 0);
      n0 = rd_count - rd_base;
      n_checks++;
      if (first_valid !== 3) $display("FAIL first_valid_latency: got %0d expected 3", first_valid);
      else n_pass++;
      n_checks++;
      if (got_data.size() !== WORDS) $display("FAIL cont_word_count: got %0d expected %0d", got_data.size(), WORDS);
      else n_pass++;
      n_checks++;
      if (stream_errors() !== 0) $display("FAIL cont_stream: got %0d bad words expected 0", stream_errors());
      else n_pass++;
      n_checks++;
      if (done_cyc !== 4100) $display("FAIL cont_done_cycle: got %0d expected 4100", done_cyc);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1) $display("FAIL cont_done_count: got %0d expected 1", done_cnt);
      else n_pass++;
      n_checks++;
      if (sat_flag !== 1'b0) $display("FAIL cont_sat_flag: got %b expected 0", sat_flag);
      else n_pass++;
      n_checks++;
      if (n0 !== WORDS || addr_err !== a0)
         $display("FAIL cont_sram_reads: got %0d reads, %0d addr errors expected %0d reads, 0 errors",
                  n0, addr_err - a0, WORDS);
      else n_pass++;
      n_checks++;
      if (nwrt_err !== e0 || post_busy !== 0)
         $display("FAIL cont_idle_after: got nwrt_err %0d busy_after %0d expected 0 0",
                  nwrt_err - e0, post_busy);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit any_over = 0;
      int o0;
      for (int i = 0; i < WORDS; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, (1 << DATA_W) - 1))
                                              : DATA_W'($urandom_range(0, (1 << OUT_W) - 1));
      mem[1] = DATA_W'((1 << OUT_W) - 1);
      mem[2] = DATA_W'(1 << OUT_W);
      mem[3] = {DATA_W{1'b1}};
      for (int i = 0; i < WORDS; i++) if (mem[i] >= (1 << OUT_W)) any_over = 1;
      o0 = ovf_cnt;
      run_sweep(30, -1, -1, 0);
      n_checks++;
      if (got_data.size() !== WORDS) $display("FAIL bp_word_count: got %0d expected %0d", got_data.size(), WORDS);
      else n_pass++;
      n_checks++;
      if (stream_errors() !== 0) $display("FAIL bp_stream: got %0d bad words expected 0", stream_errors());
      else n_pass++;
      n_checks++;
      if (unstable !== 0) $display("FAIL bp_head_stable: got %0d changes expected 0", unstable);
      else n_pass++;
      n_checks++;
      if (ovf_cnt !== o0) $display("FAIL bp_fifo_overflow: got %0d cycles expected 0", ovf_cnt - o0);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1 || sat_flag !== any_over)
         $display("FAIL bp_done_sat: got done %0d sat %b expected 1 %b", done_cnt, sat_flag, any_over);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int bad_sat = 0;
      bit exp_sat = 0;
      for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'(10);
      mem[7] = DATA_W'(4161600);
      run_sweep(100, -1, -1, 0);
      for (int i = 0; i < got_sat.size(); i++) begin
         if (mem[i] >= (1 << OUT_W)) exp_sat = 1;
         if (got_sat[i] !== exp_sat) bad_sat++;
      end
      n_checks++;
      if (got_data.size() < 8 || got_data[7] !== 16'hFFFF)
         $display("FAIL sat_word7: got %0d words, word7 %0d expected 65535",
                  got_data.size(), (got_data.size() > 7) ? got_data[7] : 0);
      else n_pass++;
      n_checks++;
      if (stream_errors() !== 0 || got_data.size() !== WORDS)
         $display("FAIL sat_stream: got %0d bad of %0d expected 0 of %0d",
                  stream_errors(), got_data.size(), WORDS);
      else n_pass++;
      n_checks++;
      if (bad_sat !== 0 || sat_flag !== 1'b1)
         $display("FAIL sat_flag_track: got %0d wrong, final %b expected 0 wrong, final 1", bad_sat, sat_flag);
      else n_pass++;
      mem[7] = DATA_W'(10);
      run_sweep(100, -1, -1, 0);
      bad_sat = 0;
      for (int i = 0; i < got_sat.size(); i++) if (got_sat[i] !== 1'b0) bad_sat++;
      n_checks++;
      if (bad_sat !== 0 || sat_flag !== 1'b0 || got_sat.size() !== WORDS)
         $display("FAIL sat_clear_on_start: got %0d set words, final %b, %0d words expected 0 0 %0d",
                  bad_sat, sat_flag, got_sat.size(), WORDS);
      else n_pass++;
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'($urandom_range(0, (1 << OUT_W) - 1));
      run_sweep(100, 50, -1, 0);
      n_checks++;
      if (got_data.size() !== WORDS || stream_errors() !== 0)
         $display("FAIL busy_start_stream: got %0d words %0d bad expected %0d 0",
                  got_data.size(), stream_errors(), WORDS);
      else n_pass++;
      n_checks++;
      if (done_cnt !== 1 || (rd_count - rd_base) !== WORDS)
         $display("FAIL busy_start_done: got done %0d reads %0d expected 1 %0d",
                  done_cnt, rd_count - rd_base, WORDS);
      else n_pass++;
   endtask

   task automatic test_fin_start();
      run_sweep(100, -1, -1, 1);
      n_checks++;
      if (done_cnt !== 1 || post_busy !== 0)
         $display("FAIL fin_start_ignored: got done %0d busy_after %0d expected 1 0", done_cnt, post_busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int r0;
      int done_seen = 0;
      logic [31:0] exp_v;
      for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'(WORDS - i);
      run_sweep(100, -1, 100, 0);
      n_checks++;
      if (aborted !== 1 || got_data.size() !== 100)
         $display("FAIL mid_reach_word100: got %0d words expected 100", got_data.size());
      else n_pass++;
      rstn = 1'b0;
      #1;
      exp_v = {1'b1, 1'b1, 12'd0, 1'b0, 16'd0};
      n_checks++;
      if ({NCE_C, nwrt_C, address_C, out_valid, out_data} !== exp_v ||
          {out_addr, sat_flag, busy, done} !== 15'd0)
         $display("FAIL mid_reset_outputs: got %h %h expected %h 0",
                  {NCE_C, nwrt_C, address_C, out_valid, out_data},
                  {out_addr, sat_flag, busy, done}, exp_v);
      else n_pass++;
      r0 = rd_count;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      n_checks++;
      if (rd_count !== r0 || done_seen !== 0)
         $display("FAIL mid_reset_quiet: got %0d reads %0d done expected 0 0", rd_count - r0, done_seen);
      else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      run_sweep(100, -1, -1, 0);
      n_checks++;
      if (got_data.size() !== WORDS || stream_errors() !== 0 || done_cnt !== 1 || first_valid !== 3)
         $display("FAIL mid_resweep: got %0d words %0d bad done %0d latency %0d expected %0d 0 1 3",
                  got_data.size(), stream_errors(), done_cnt, first_valid, WORDS);
      else n_pass++;
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < WORDS; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      test_continuous();
      test_backpressure();
      test_saturation();
      test_start_busy();
      test_fin_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
